cxapbsyncbridge: RTL and testbench
==================================

# cxapbsyncbridge

Single-clock APB4 bridge between two clock-enable domains sharing `pclk`: a slave port qualified by `pclkens` and a master port qualified by `pclkenm`. It is the same-clock successor of the APB asynchronous bridge and differs from it in four ways:
- address and data widths are parameters;
- APB4 `PPROT`/`PSTRB` are forwarded;
- an optional access timeout completes stalled master transfers with an error;
- the crossing uses enable-qualified registers instead of req/ack synchronisers.

It sits between a fast-enable APB segment (CPU side) and a slow-enable peripheral segment.

## Interface
- `ADDR_WIDTH`, 32, address width, 12..32.
- `DATA_WIDTH`, 32, data width, one of 8/16/32; strobe width `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 0, number of master-enabled access cycles before abort; 0 disables the timeout.
- `pclk` input 1: single clock for both sides.
- `presetn` input 1: reset, asynchronous assert, active-low.
- `pclkens` input 1: slave-side clock enable.
- `pclkenm` input 1: master-side clock enable.
- `psels`, `penables`, `pwrites` input 1: slave APB control.
- `paddrs` input `ADDR_WIDTH`; `pwdatas` input `DATA_WIDTH`; `pprots` input 3; `pstrbs` input `DATA_WIDTH/8`.
- `prdatas` output `DATA_WIDTH`; `pslverrs` output 1; `preadys` output 1.
- `pselm`, `penablem`, `pwritem` output 1: master APB control.
- `paddrm` output `ADDR_WIDTH`; `pwdatam` output `DATA_WIDTH`; `pprotm` output 3; `pstrbm` output `DATA_WIDTH/8`.
- `prdatam` input `DATA_WIDTH`; `pslverrm` input 1; `preadym` input 1.
- `busy` output 1: high in any state other than IDLE.

## Operation
- State machine states: IDLE, MREQ, MSETUP, MACCESS, SRESP. All registers are on `pclk` posedge and reset asynchronously on `presetn` low.
- **IDLE**
  - On `pclkens & psels & ~penables`: capture address, write, prot, wdata and strb into request registers, then go to MREQ.
  - For a read, `pstrb` is captured as all-zero regardless of `pstrbs`.
- **MREQ**
  - On `pclkenm`: set `pselm`=1, `penablem`=0, drive the master bus from the request registers, then go to MSETUP.
- **MSETUP**
  - On `pclkenm`: set `penablem`=1, clear the timeout counter, then go to MACCESS.
- **MACCESS**, on each `pclkenm` edge:
  - If `preadym`=1: capture `prdatam` (capture is forced to 0 for writes) and `pslverrm`, drop `pselm`/`penablem`, go to SRESP.
  - Else, if `TIMEOUT_CYCLES`>0 and the counter equals `TIMEOUT_CYCLES`-1: drop `pselm`/`penablem`, capture rdata=0 and err=1, go to SRESP.
  - Else: increment the counter.
- **SRESP**
  - `preadys`=1 combinationally from the state.
  - On `pclkens`: go to IDLE. This is the edge on which the slave samples the completion.
- `preadys`=0 in every state except SRESP. The slave therefore sees wait states from its access phase until the response is ready.
- `prdatas` and `pslverrs` come from the response registers. They are valid whenever `preadys`=1 and hold their value until the next response.
- After a transfer, `paddrm`, `pwritem`, `pwdatam`, `pprotm` and `pstrbm` hold their last values; only `pselm` and `penablem` return to 0.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. It saturates and never wraps.
- When `pclkens` and `pclkenm` are high on the same edge, each state uses only its own governing enable. No transition skips a state.
- `psels` deasserting while not in IDLE is a protocol violation by the upstream master. The bridge ignores it and completes the transfer.

## Timing
- Reset values:
  - state IDLE;
  - `pselm`, `penablem`, `pwritem` = 0;
  - `paddrm`, `pwdatam`, `pprotm`, `pstrbm` = 0;
  - `prdatas`, `pslverrs` = 0;
  - `preadys`=0, `busy`=0.
- Reset mid-transfer aborts immediately: master outputs return to 0, no response is given, and the slave-side transfer is lost.
- Latency with both enables permanently high and a zero-wait slave:
  - capture edge T0; `pselm` at T1; `penablem` at T2;
  - completion edge T3; `preadys`=1 during T3..T4; IDLE at T4.
  - The slave sees 3 wait states.
- Minimum re-issue: a new setup phase can be captured on the first `pclkens` edge in IDLE, i.e. back-to-back with no bubble beyond the IDLE cycle.
- With `TIMEOUT_CYCLES`=N, the abort occurs on the N-th `pclkenm` edge in MACCESS with `preadym` low.
- No combinational path from any slave input to any master output, or the reverse. The only combinational output is `preadys` (decoded from state).

## Test plan
- **Enables high, write** `paddrs`=0x40001004, `pwdatas`=0xA5A5_1234, `pstrbs`=0xF, `pprots`=3'b010, zero-wait slave -> master shows a setup and an access with those values; `preadys`=1 exactly one cycle, at T3; `pslverrs`=0.
- **`pclkenm` every 4th cycle, `pclkens` every cycle, read**, slave returns 0xDEADBEEF with 2 wait states -> `penablem` held across 3 enabled edges; `prdatas`=0xDEADBEEF; `pselm`/`penablem` toggle only on `pclkenm` edges.
- **`TIMEOUT_CYCLES`=4, `preadym` stuck low** -> `pselm` drops on the 4th enabled MACCESS edge; `pslverrs`=1; `prdatas`=0; next transfer then proceeds normally.
- **`pslverrm`=1 on a read returning 0x55** -> `pslverrs`=1, `prdatas`=0x55. On a write -> `prdatas`=0.
- **Read with `pstrbs`=0xF** -> `pstrbm`=0. Back-to-back write then read -> the read is captured on the first `pclkens` edge after returning to IDLE.
- **`presetn` low during MACCESS** -> all outputs at reset values asynchronously, without a clock edge; `busy`=0; a following transfer completes normally.

Source files
------------

// File: rtl/cxapbsyncbridge.sv
// Single-clock APB4 bridge between a pclkens-qualified slave port and a
// pclkenm-qualified master port, with an optional master access timeout.
module cxapbsyncbridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    pclkens,
    input  logic                    pclkenm,
    // slave port
    input  logic                    psels,
    input  logic                    penables,
    input  logic                    pwrites,
    input  logic [ADDR_WIDTH-1:0]   paddrs,
    input  logic [DATA_WIDTH-1:0]   pwdatas,
    input  logic [2:0]              pprots,
    input  logic [DATA_WIDTH/8-1:0] pstrbs,
    output logic [DATA_WIDTH-1:0]   prdatas,
    output logic                    pslverrs,
    output logic                    preadys,
    // master port
    output logic                    pselm,
    output logic                    penablem,
    output logic                    pwritem,
    output logic [ADDR_WIDTH-1:0]   paddrm,
    output logic [DATA_WIDTH-1:0]   pwdatam,
    output logic [2:0]              pprotm,
    output logic [DATA_WIDTH/8-1:0] pstrbm,
    input  logic [DATA_WIDTH-1:0]   prdatam,
    input  logic                    pslverrm,
    input  logic                    preadym,
    output logic                    busy
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit          TMO_EN     = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_WIDTH  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        TMO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        MREQ,
        MSETUP,
        MACCESS,
        SRESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  cap_req;
    logic                  issue;
    logic                  start_access;
    logic                  complete;
    logic                  abort;
    logic                  cnt_inc;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [2:0]            req_prot;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic [CNT_WIDTH-1:0]  tmo_cnt;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state advances only on its own side's enable, so simultaneous
    // enables never let a transfer skip a state.
    always_comb begin
        state_nxt    = state;
        cap_req      = 1'b0;
        issue        = 1'b0;
        start_access = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;
        cnt_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (pclkens && psels && !penables) begin
                    cap_req   = 1'b1;
                    state_nxt = MREQ;
                end
            end
            MREQ: begin
                if (pclkenm) begin
                    issue     = 1'b1;
                    state_nxt = MSETUP;
                end
            end
            MSETUP: begin
                if (pclkenm) begin
                    start_access = 1'b1;
                    state_nxt    = MACCESS;
                end
            end
            MACCESS: begin
                if (pclkenm) begin
                    if (preadym) begin
                        complete  = 1'b1;
                        state_nxt = SRESP;
                    end else if (TMO_EN && (tmo_cnt == CNT_LAST)) begin
                        abort     = 1'b1;
                        state_nxt = SRESP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            SRESP: begin
                if (pclkens) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            req_prot  <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
        end else if (cap_req) begin
            req_addr  <= paddrs;
            req_write <= pwrites;
            req_prot  <= pprots;
            req_wdata <= pwdatas;
            req_strb  <= pwrites ? pstrbs : '0;
        end
    end

    // Address/data/attributes hold their last values between transfers;
    // only the select and enable strobes return low.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pselm    <= 1'b0;
            penablem <= 1'b0;
            pwritem  <= 1'b0;
            paddrm   <= '0;
            pwdatam  <= '0;
            pprotm   <= '0;
            pstrbm   <= '0;
        end else begin
            if (issue) begin
                pselm    <= 1'b1;
                penablem <= 1'b0;
                pwritem  <= req_write;
                paddrm   <= req_addr;
                pwdatam  <= req_wdata;
                pprotm   <= req_prot;
                pstrbm   <= req_strb;
            end
            if (start_access) begin
                penablem <= 1'b1;
            end
            if (complete || abort) begin
                pselm    <= 1'b0;
                penablem <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt <= '0;
        end else if (start_access) begin
            tmo_cnt <= '0;
        end else if (cnt_inc && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (complete) begin
            rsp_rdata <= pwritem ? '0 : prdatam;
            rsp_err   <= pslverrm;
        end else if (abort) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end
    end

    assign prdatas  = rsp_rdata;
    assign pslverrs = rsp_err;
    assign preadys  = (state == SRESP);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cxapbsyncbridge.sv
// Self-checking bench for cxapbsyncbridge: directed scenarios plus randomized
// transfers, checked every cycle against a transfer-progress reference model.
module tb_cxapbsyncbridge;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          pclkens = 1'b0;
    logic          pclkenm = 1'b0;
    logic          psels = 1'b0;
    logic          penables = 1'b0;
    logic          pwrites = 1'b0;
    logic [AW-1:0] paddrs = '0;
    logic [DW-1:0] pwdatas = '0;
    logic [2:0]    pprots = '0;
    logic [SW-1:0] pstrbs = '0;
    logic [DW-1:0] prdatas;
    logic          pslverrs;
    logic          preadys;
    logic          pselm;
    logic          penablem;
    logic          pwritem;
    logic [AW-1:0] paddrm;
    logic [DW-1:0] pwdatam;
    logic [2:0]    pprotm;
    logic [SW-1:0] pstrbm;
    logic [DW-1:0] prdatam = '0;
    logic          pslverrm = 1'b0;
    logic          preadym = 1'b0;
    logic          busy;

    always #5 pclk = ~pclk;

    cxapbsyncbridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk), .presetn(presetn), .pclkens(pclkens), .pclkenm(pclkenm),
        .psels(psels), .penables(penables), .pwrites(pwrites), .paddrs(paddrs),
        .pwdatas(pwdatas), .pprots(pprots), .pstrbs(pstrbs), .prdatas(prdatas),
        .pslverrs(pslverrs), .preadys(preadys), .pselm(pselm), .penablem(penablem),
        .pwritem(pwritem), .paddrm(paddrm), .pwdatam(pwdatam), .pprotm(pprotm),
        .pstrbm(pstrbm), .prdatam(prdatam), .pslverrm(pslverrm), .preadym(preadym),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: progress of the one outstanding transfer
    // (0 none, 1 captured, 2 master setup, 3 master access, 4 response shown).
    int            m_stage = 0;
    int            m_acc = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [2:0]    m_prot = '0;
    logic [SW-1:0] m_strb = '0;
    logic          e_pwritem = 1'b0;
    logic [AW-1:0] e_paddrm = '0;
    logic [DW-1:0] e_pwdatam = '0;
    logic [2:0]    e_pprotm = '0;
    logic [SW-1:0] e_pstrbm = '0;
    logic [DW-1:0] e_prdatas = '0;
    logic          e_pslverrs = 1'b0;

    task automatic model_reset;
        m_stage = 0; m_acc = 0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_prot = '0; m_strb = '0;
        e_pwritem = 1'b0; e_paddrm = '0; e_pwdatam = '0; e_pprotm = '0; e_pstrbm = '0;
        e_prdatas = '0; e_pslverrs = 1'b0;
    endtask

    // Advances the model with the inputs the coming clock edge will see.
    task automatic model_step;
        if (!presetn) begin
            model_reset();
            return;
        end
        case (m_stage)
            0: if (pclkens && psels && !penables) begin
                m_wr = pwrites; m_addr = paddrs; m_wdata = pwdatas; m_prot = pprots;
                m_strb = pwrites ? pstrbs : '0;
                m_stage = 1;
            end
            1: if (pclkenm) begin
                e_pwritem = m_wr; e_paddrm = m_addr; e_pwdatam = m_wdata;
                e_pprotm = m_prot; e_pstrbm = m_strb;
                m_stage = 2;
            end
            2: if (pclkenm) begin
                m_acc = 0;
                m_stage = 3;
            end
            3: if (pclkenm) begin
                if (preadym) begin
                    e_prdatas = m_wr ? '0 : prdatam;
                    e_pslverrs = pslverrm;
                    m_stage = 4;
                end else begin
                    m_acc++;
                    if (m_acc == int'(TMO)) begin
                        e_prdatas = '0;
                        e_pslverrs = 1'b1;
                        m_stage = 4;
                    end
                end
            end
            4: if (pclkens) m_stage = 0;
            default: ;
        endcase
    endtask

    // Peripheral behind the master port and enable generation.
    int            en_mode = 0;
    int            cyc = 0;
    int            pw_waits = 0;
    int            pw_cnt = 0;
    bit            pw_stuck = 1'b0;
    logic          pw_err = 1'b0;
    logic [DW-1:0] pw_rdata = '0;
    int            acc_edges = 0;
    int            setup_ticks = 0;
    bit            s_done = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic          s_err = 1'b0;

    // Called just after a negedge: sets inputs for the next posedge, steps the
    // model, then waits for the following negedge.
    task automatic tick;
        cyc++;
        case (en_mode)
            0: begin pclkens = 1'b1; pclkenm = 1'b1; end
            1: begin pclkens = 1'b1; pclkenm = ((cyc % 4) == 0); end
            default: begin
                pclkens = ($urandom_range(0, 99) < 70);
                pclkenm = ($urandom_range(0, 1) == 1);
            end
        endcase
        if (!penablem) pw_cnt = 0;
        preadym  = penablem && !pw_stuck && (pw_cnt >= pw_waits);
        prdatam  = pw_rdata;
        pslverrm = pw_err;
        if (pclkenm && penablem) begin
            acc_edges++;
            if (!preadym) pw_cnt++;
        end
        s_done  = pclkens && preadys;
        s_rdata = prdatas;
        s_err   = pslverrs;
        model_step();
        @(negedge pclk);
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] strb, input logic [2:0] prot,
                            output logic [DW-1:0] rdata, output logic err);
        bit tmo;
        int n;
        psels = 1'b1; penables = 1'b0; pwrites = wr;
        paddrs = addr; pwdatas = wdata; pstrbs = strb; pprots = prot;
        setup_ticks = 0;
        do begin
            tick();
            setup_ticks++;
        end while (!pclkens && setup_ticks < 200);
        if (!pclkens) chk("setup_wait", 0, 1);
        penables = 1'b1;
        acc_edges = 0;
        n = 0;
        s_done = 1'b0;
        while (!s_done && n < 400) begin
            tick();
            n++;
        end
        if (!s_done) chk("resp_wait", 0, 1);
        psels = 1'b0; penables = 1'b0;
        rdata = s_rdata;
        err = s_err;
        tmo = pw_stuck || (pw_waits >= int'(TMO));
        chk("xfer_err", err, tmo ? 1'b1 : pw_err);
        chk("xfer_rdata", rdata, (tmo || wr) ? '0 : pw_rdata);
    endtask

    // Per-cycle comparison against the model, sampled after each edge.
    logic prev_sel = 1'b0;
    logic prev_en = 1'b0;
    always @(posedge pclk) begin
        #1;
        chk("pselm", pselm, (m_stage == 2) || (m_stage == 3));
        chk("penablem", penablem, m_stage == 3);
        chk("busy", busy, m_stage != 0);
        chk("preadys", preadys, m_stage == 4);
        chk("pwritem", pwritem, e_pwritem);
        chk("paddrm", paddrm, e_paddrm);
        chk("pwdatam", pwdatam, e_pwdatam);
        chk("pprotm", pprotm, e_pprotm);
        chk("pstrbm", pstrbm, e_pstrbm);
        chk("prdatas", prdatas, e_prdatas);
        chk("pslverrs", pslverrs, e_pslverrs);
        if (presetn && (pselm !== prev_sel || penablem !== prev_en))
            chk("strobe_on_enm", pclkenm, 1'b1);
        prev_sel = pselm;
        prev_en  = penablem;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] rd;
    logic          er;

    initial begin
        model_reset();
        repeat (3) @(negedge pclk);
        chk("rst_busy", busy, 0);
        chk("rst_preadys", preadys, 0);
        chk("rst_pselm", pselm, 0);
        chk("rst_paddrm", paddrm, 0);
        presetn = 1'b1;

        // Both enables high, zero-wait write: cycle-exact latency.
        en_mode = 0; pw_waits = 0; pw_err = 1'b0; pw_rdata = 32'h1357_9BDF;
        psels = 1'b1; penables = 1'b0; pwrites = 1'b1; paddrs = 32'h4000_1004;
        pwdatas = 32'hA5A5_1234; pstrbs = 4'hF; pprots = 3'b010;
        tick();
        chk("t0_busy", busy, 1);
        chk("t0_pselm", pselm, 0);
        penables = 1'b1;
        tick();
        chk("t1_pselm", pselm, 1);
        chk("t1_penablem", penablem, 0);
        chk("t1_paddrm", paddrm, 32'h4000_1004);
        chk("t1_pwdatam", pwdatam, 32'hA5A5_1234);
        chk("t1_pstrbm", pstrbm, 4'hF);
        chk("t1_pprotm", pprotm, 3'b010);
        chk("t1_pwritem", pwritem, 1);
        tick();
        chk("t2_penablem", penablem, 1);
        chk("t2_preadys", preadys, 0);
        tick();
        chk("t3_preadys", preadys, 1);
        chk("t3_pselm", pselm, 0);
        chk("t3_pslverrs", pslverrs, 0);
        chk("t3_prdatas", prdatas, 0);
        tick();
        chk("t4_preadys", preadys, 0);
        chk("t4_busy", busy, 0);
        psels = 1'b0; penables = 1'b0;

        // Slow master enable, read with two wait states.
        en_mode = 1; pw_waits = 2; pw_rdata = 32'hDEAD_BEEF;
        apb_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 3'b000, rd, er);
        chk("t2_acc_edges", acc_edges, 3);
        chk("t2_rdata", rd, 32'hDEAD_BEEF);
        chk("t2_model_rdata", e_prdatas, 32'hDEAD_BEEF);

        // Stuck peripheral: timeout on the 4th access edge, then recovery.
        en_mode = 0; pw_stuck = 1'b1;
        apb_xfer(1'b0, 32'h0000_0300, 32'h0, 4'h0, 3'b001, rd, er);
        chk("t3_acc_edges", acc_edges, 4);
        chk("t3_err", er, 1);
        chk("t3_rdata", rd, 0);
        pw_stuck = 1'b0; pw_waits = 1; pw_rdata = 32'h0BAD_F00D;
        apb_xfer(1'b0, 32'h0000_0304, 32'h0, 4'h0, 3'b001, rd, er);
        chk("t3_next_err", er, 0);
        chk("t3_next_rdata", rd, 32'h0BAD_F00D);

        // Error responses.
        pw_waits = 0; pw_err = 1'b1; pw_rdata = 32'h55;
        apb_xfer(1'b0, 32'h0000_0400, 32'h0, 4'h0, 3'b000, rd, er);
        chk("t4_rd_err", er, 1);
        chk("t4_rd_data", rd, 32'h55);
        apb_xfer(1'b1, 32'h0000_0404, 32'h1111_2222, 4'h3, 3'b000, rd, er);
        chk("t4_wr_err", er, 1);
        chk("t4_wr_data", rd, 0);
        pw_err = 1'b0;

        // Read strobes forced low; back-to-back write then read.
        apb_xfer(1'b0, 32'h0000_0500, 32'h0, 4'hF, 3'b000, rd, er);
        chk("t5_pstrbm", pstrbm, 0);
        apb_xfer(1'b1, 32'h0000_0504, 32'hCAFE_0001, 4'hC, 3'b100, rd, er);
        apb_xfer(1'b0, 32'h0000_0508, 32'h0, 4'hF, 3'b100, rd, er);
        chk("t5_b2b_setup_ticks", setup_ticks, 1);

        // Asynchronous reset in the access phase.
        pw_stuck = 1'b1;
        psels = 1'b1; penables = 1'b0; pwrites = 1'b1; paddrs = 32'h0000_0600;
        pwdatas = 32'h7777_8888; pstrbs = 4'hF; pprots = 3'b011;
        tick();
        penables = 1'b1;
        tick();
        tick();
        chk("t6_pre_penablem", penablem, 1);
        #2;
        presetn = 1'b0;
        #1;
        chk("t6_pselm", pselm, 0);
        chk("t6_penablem", penablem, 0);
        chk("t6_paddrm", paddrm, 0);
        chk("t6_pwdatam", pwdatam, 0);
        chk("t6_pwritem", pwritem, 0);
        chk("t6_busy", busy, 0);
        chk("t6_preadys", preadys, 0);
        model_reset();
        psels = 1'b0; penables = 1'b0; pw_stuck = 1'b0;
        @(negedge pclk);
        tick();
        presetn = 1'b1;
        pw_waits = 0; pw_rdata = 32'h2468_ACE0;
        apb_xfer(1'b0, 32'h0000_0610, 32'h0, 4'h0, 3'b000, rd, er);
        chk("t6_after_rdata", rd, 32'h2468_ACE0);

        // Randomized traffic with random enables, waits and errors.
        en_mode = 2;
        for (int unsigned i = 0; i < 200; i++) begin
            pw_waits = $urandom_range(0, 5);
            pw_err   = ($urandom_range(0, 3) == 0);
            pw_rdata = $urandom;
            apb_xfer($urandom_range(0, 1) == 1, $urandom, $urandom,
                     SW'($urandom), 3'($urandom), rd, er);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
